// File: rtl/sc_backg_shift_controller.sv
// -----------------------------------------------------------------------------
// sc_backg_shift_controller
//
// Purpose:
//   Sequencer that sits directly in front of the background-type register.
//   It clears the register while idle, loads the pattern of the current level,
//   rotates the pattern one position every TICK_DIV cycles, and after
//   SHIFTS_PER_LEVEL rotations pulses a level transition. The next level's
//   pattern is then loaded, and the sequence repeats over four levels.
//
// Ports:
//   SC_RegBACKGTYPE_CLOCK_50     system clock
//   SC_RegBACKGTYPE_RESET_InHigh asynchronous, active-high reset
//   start_In                     one-cycle pulse; starts a level from IDLE
//   stop_In                      level; returns to IDLE and keeps the level
//   pause_In                     level; freezes the prescaler while running
//   direction_In                 0 = rotate left (01), 1 = rotate right (10)
//   clear_OutLow                 active-low clear to the register
//   load_OutLow                  active-low load to the register
//   shiftselection_Out           00 hold, 01 left, 10 right
//   transition_Out               one-cycle level-transition pulse
//   data_OutBUS                  pattern of the current level
//   level_Out                    current level index
// -----------------------------------------------------------------------------
module sc_backg_shift_controller #(
   parameter int                   DATAWIDTH        = 8,
   parameter int                   TICK_DIV         = 25000000,
   parameter int                   TICK_WIDTH       = 25,
   parameter int                   SHIFTS_PER_LEVEL = 8,
   parameter logic [DATAWIDTH-1:0] PATTERN_L0       = DATAWIDTH'(8'b00000001),
   parameter logic [DATAWIDTH-1:0] PATTERN_L1       = DATAWIDTH'(8'b00010001),
   parameter logic [DATAWIDTH-1:0] PATTERN_L2       = DATAWIDTH'(8'b01010101),
   parameter logic [DATAWIDTH-1:0] PATTERN_L3       = DATAWIDTH'(8'b11110000)
) (
   input  logic                 SC_RegBACKGTYPE_CLOCK_50,
   input  logic                 SC_RegBACKGTYPE_RESET_InHigh,
   input  logic                 start_In,
   input  logic                 stop_In,
   input  logic                 pause_In,
   input  logic                 direction_In,
   output logic                 clear_OutLow,
   output logic                 load_OutLow,
   output logic [1:0]           shiftselection_Out,
   output logic                 transition_Out,
   output logic [DATAWIDTH-1:0] data_OutBUS,
   output logic [1:0]           level_Out
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_TRANS = 2'd3;

   localparam logic [TICK_WIDTH-1:0] PRESC_LAST = TICK_WIDTH'(TICK_DIV - 1);
   localparam logic [TICK_WIDTH-1:0] PRESC_ONE  = TICK_WIDTH'(1);
   localparam logic [7:0]            SHIFT_LAST = 8'(SHIFTS_PER_LEVEL);

   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_LEFT  = 2'b01;
   localparam logic [1:0] SEL_RIGHT = 2'b10;

   function automatic logic [DATAWIDTH-1:0] pattern_of(input logic [1:0] lvl);
      logic [DATAWIDTH-1:0] p;
      case (lvl)
         2'd0:    p = PATTERN_L0;
         2'd1:    p = PATTERN_L1;
         2'd2:    p = PATTERN_L2;
         default: p = PATTERN_L3;
      endcase
      return p;
   endfunction

   logic [1:0]            state_q,  state_d;
   logic [1:0]            level_q,  level_d;
   logic [TICK_WIDTH-1:0] presc_q,  presc_d;
   logic [7:0]            shcnt_q,  shcnt_d;
   logic                  clear_q,  clear_d;
   logic                  load_q,   load_d;
   logic [1:0]            sel_q,    sel_d;
   logic                  trans_q,  trans_d;
   logic [DATAWIDTH-1:0]  data_q;

   // Every output is registered, so the combinational block computes the
   // control values that belong to the *next* state alongside the state itself.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      presc_d = presc_q;
      shcnt_d = shcnt_q;
      clear_d = 1'b1;
      load_d  = 1'b1;
      sel_d   = SEL_HOLD;
      trans_d = 1'b0;

      if (stop_In) begin
         // Level is kept so that the next start resumes where play stopped.
         state_d = ST_IDLE;
         clear_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               clear_d = 1'b0;
               if (start_In) begin
                  state_d = ST_LOAD;
                  clear_d = 1'b1;
                  load_d  = 1'b0;
                  presc_d = '0;
                  shcnt_d = '0;
               end
            end

            ST_LOAD: begin
               // The LOAD cycle counts as the first prescaler cycle, so the
               // first shift pulse lands exactly TICK_DIV cycles after LOAD.
               state_d = ST_RUN;
               presc_d = PRESC_ONE;
               shcnt_d = '0;
            end

            ST_RUN: begin
               if (shcnt_q == SHIFT_LAST) begin
                  // Reached in the final pulse cycle; the transition outranks pause.
                  state_d = ST_TRANS;
                  trans_d = 1'b1;
               end else if (!pause_In) begin
                  if (presc_q == PRESC_LAST) begin
                     presc_d = '0;
                     shcnt_d = shcnt_q + 8'd1;
                     sel_d   = direction_In ? SEL_RIGHT : SEL_LEFT;
                  end else begin
                     presc_d = presc_q + PRESC_ONE;
                  end
               end
            end

            default: begin // ST_TRANS
               state_d = ST_LOAD;
               load_d  = 1'b0;
               level_d = level_q + 2'd1;
               presc_d = '0;
               shcnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
      if (SC_RegBACKGTYPE_RESET_InHigh) begin
         state_q <= ST_IDLE;
         level_q <= 2'd0;
         presc_q <= '0;
         shcnt_q <= '0;
         clear_q <= 1'b0;
         load_q  <= 1'b1;
         sel_q   <= SEL_HOLD;
         trans_q <= 1'b0;
         data_q  <= PATTERN_L0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         presc_q <= presc_d;
         shcnt_q <= shcnt_d;
         clear_q <= clear_d;
         load_q  <= load_d;
         sel_q   <= sel_d;
         trans_q <= trans_d;
         data_q  <= pattern_of(level_d);
      end
   end

   assign clear_OutLow       = clear_q;
   assign load_OutLow        = load_q;
   assign shiftselection_Out = sel_q;
   assign transition_Out     = trans_q;
   assign data_OutBUS        = data_q;
   assign level_Out          = level_q;

endmodule

// File: tb/tb_sc_backg_shift_controller.sv
// -----------------------------------------------------------------------------
// tb_sc_backg_shift_controller
//
// Bench for sc_backg_shift_controller with a short prescaler (TICK_DIV = 4)
// and three shifts per level. A behavioural model tracks the number of
// elapsed, unpaused ticks since the last load and derives the pulses and
// transitions from it arithmetically. The bench compares every cycle's
// outputs against the model, with directed sequences followed by random
// stimulus.
// -----------------------------------------------------------------------------
module tb_sc_backg_shift_controller;

   localparam int DW  = 8;
   localparam int TD  = 4;
   localparam int TW  = 3;
   localparam int SPL = 3;

   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_RUN   = 2;
   localparam int M_TRANS = 3;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic          stop  = 1'b0;
   logic          pause = 1'b0;
   logic          dir   = 1'b0;
   logic          clear_n;
   logic          load_n;
   logic [1:0]    sel;
   logic          trans;
   logic [DW-1:0] data;
   logic [1:0]    level;

   logic [DW-1:0] pat [4];

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int         m_mode;
   int         m_level;
   int         m_ticks;
   logic       e_clear;
   logic       e_load;
   logic [1:0] e_sel;
   logic       e_trans;

   always #5 clk = ~clk;

   sc_backg_shift_controller #(
      .DATAWIDTH        (DW),
      .TICK_DIV         (TD),
      .TICK_WIDTH       (TW),
      .SHIFTS_PER_LEVEL (SPL)
   ) dut (
      .SC_RegBACKGTYPE_CLOCK_50     (clk),
      .SC_RegBACKGTYPE_RESET_InHigh (rst),
      .start_In                     (start),
      .stop_In                      (stop),
      .pause_In                     (pause),
      .direction_In                 (dir),
      .clear_OutLow                 (clear_n),
      .load_OutLow                  (load_n),
      .shiftselection_Out           (sel),
      .transition_Out               (trans),
      .data_OutBUS                  (data),
      .level_Out                    (level)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
   endtask

   task automatic set_exp(input logic c, input logic l, input logic [1:0] s, input logic t);
      e_clear = c;
      e_load  = l;
      e_sel   = s;
      e_trans = t;
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_level = 0;
      m_ticks = 0;
      set_exp(1'b0, 1'b1, 2'b00, 1'b0);
   endtask

   // Advance the model by one clock edge using the inputs of the cycle
   // that just ended. m_ticks counts the LOAD cycle plus every unpaused
   // RUN cycle; a shift is due whenever it reaches a multiple of TD.
   task automatic model_step();
      if (rst) begin
         model_reset();
      end else if (stop) begin
         m_mode = M_IDLE;
         set_exp(1'b0, 1'b1, 2'b00, 1'b0);
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (start) begin
                  m_mode  = M_LOAD;
                  m_ticks = 0;
                  set_exp(1'b1, 1'b0, 2'b00, 1'b0);
               end else begin
                  set_exp(1'b0, 1'b1, 2'b00, 1'b0);
               end
            end
            M_LOAD: begin
               m_mode  = M_RUN;
               m_ticks = 1;
               set_exp(1'b1, 1'b1, 2'b00, 1'b0);
            end
            M_RUN: begin
               if (m_ticks / TD >= SPL) begin
                  m_mode = M_TRANS;
                  set_exp(1'b1, 1'b1, 2'b00, 1'b1);
               end else if (!pause) begin
                  m_ticks++;
                  if (m_ticks % TD == 0) set_exp(1'b1, 1'b1, dir ? 2'b10 : 2'b01, 1'b0);
                  else                   set_exp(1'b1, 1'b1, 2'b00, 1'b0);
               end else begin
                  set_exp(1'b1, 1'b1, 2'b00, 1'b0);
               end
            end
            default: begin
               m_level = (m_level + 1) % 4;
               m_mode  = M_LOAD;
               set_exp(1'b1, 1'b0, 2'b00, 1'b0);
            end
         endcase
      end
   endtask

   task automatic compare_all();
      check_val("ctrl",  {clear_n, load_n, sel, trans}, {e_clear, e_load, e_sel, e_trans});
      check_val("level", level, m_level[1:0]);
      check_val("data",  data, pat[m_level]);
      check_val("excl",  $onehot0({~load_n, (sel != 2'b00), trans}), 1);
   endtask

   task automatic step(input logic s, input logic p, input logic d, input logic sp);
      start = s;
      pause = p;
      dir   = d;
      stop  = sp;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   // Called at a falling edge: reset takes effect without waiting for a clock.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      step(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   int n_tr;
   int cyc;
   int pulse_no;
   int second_pulse_cyc;
   logic [1:0] second_pulse_sel;

   initial begin
      pat[0] = 8'b00000001;
      pat[1] = 8'b00010001;
      pat[2] = 8'b01010101;
      pat[3] = 8'b11110000;
      model_reset();

      @(negedge clk);
      do_reset();

      // four complete levels rotating left
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n_tr = 0;
      repeat (60) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         if (trans) n_tr++;
      end
      check_val("four_transitions", n_tr, 4);
      check_val("level_wrapped", level, 2'd0);

      // pause for 10 cycles in RUN, rotating right
      do_reset();
      step(1'b1, 1'b0, 1'b1, 1'b0);
      cyc = 0;
      pulse_no = 0;
      second_pulse_cyc = -1;
      second_pulse_sel = 2'b00;
      for (int k = 1; k <= 30; k++) begin
         step(1'b0, (k >= 6 && k <= 15), 1'b1, 1'b0);
         cyc++;
         if (sel != 2'b00) begin
            pulse_no++;
            if (pulse_no == 2) begin
               second_pulse_cyc = cyc;
               second_pulse_sel = sel;
            end
         end
      end
      check_val("paused_pulse_cycle", second_pulse_cyc, 18);
      check_val("paused_pulse_dir", second_pulse_sel, 2'b10);

      // stop in level 2 RUN, then resume at level 2
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (31) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check_val("stop_clear", clear_n, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("resume_load", load_n, 1'b0);
      check_val("resume_data", data, 8'b01010101);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);

      // reset in the middle of RUN
      do_reset();
      check_val("rst_level", level, 2'd0);
      check_val("rst_data", data, 8'b00000001);

      // random traffic
      repeat (3000) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            step(($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sc_backg_shift_controller.md
Name: sc_backg_shift_controller

Overview:
- Control sequencer directly upstream of the background-type register.
- Generates the register's clear, load, shift-select and level-transition controls, plus the per-level pattern to load.
- Drives a background pattern that rotates at a prescaled rate, then advances to the next level after a fixed number of shifts.
- Sits between the game-level FSM/switch inputs and the background register.

Parameters:
DATAWIDTH, 8, width of pattern bus (matches background register width)
TICK_DIV, 25000000, clock cycles between shift pulses (minimum 2)
TICK_WIDTH, 25, width of prescaler counter (2^TICK_WIDTH > TICK_DIV)
SHIFTS_PER_LEVEL, 8, shift pulses per level before a transition (1..255)
PATTERN_L0, 8'b00000001, pattern loaded for level 0
PATTERN_L1, 8'b00010001, pattern loaded for level 1
PATTERN_L2, 8'b01010101, pattern loaded for level 2
PATTERN_L3, 8'b11110000, pattern loaded for level 3

Ports:
SC_RegBACKGTYPE_CLOCK_50  in  1  system clock
SC_RegBACKGTYPE_RESET_InHigh  in  1  asynchronous, active-high reset
start_In  in  1  one-cycle pulse; leaves IDLE
stop_In  in  1  level; forces IDLE
pause_In  in  1  level; freezes the prescaler while in RUN
direction_In  in  1  0 = rotate left (select 01), 1 = rotate right (select 10)
clear_OutLow  out  1  active-low clear to the register
load_OutLow  out  1  active-low load to the register
shiftselection_Out  out  2  00 hold, 01 left, 10 right
transition_Out  out  1  one-cycle level-transition pulse
data_OutBUS  out  DATAWIDTH  pattern for the current level
level_Out  out  2  current level index

Behaviour:
- All outputs are registered and change only on a clock edge.
- Reset values:
  - state = IDLE, level = 0, prescaler = 0, shift count = 0.
  - clear_OutLow = 0, load_OutLow = 1, shiftselection_Out = 00, transition_Out = 0.
  - data_OutBUS = PATTERN_L0.
- data_OutBUS = PATTERN_L[level] at all times; it updates in the same edge as level.
- States:
  - IDLE: clear_OutLow = 0, all other controls inactive.
    - start_In = 1 -> LOAD.
  - LOAD: lasts exactly 1 cycle. load_OutLow = 0, clear_OutLow = 1. Prescaler and shift count are zeroed.
    - -> RUN.
  - RUN: prescaler increments each cycle unless pause_In = 1.
    - When the prescaler reaches TICK_DIV-1, it wraps to 0.
    - On that wrap, shiftselection_Out = (direction_In ? 10 : 01) for exactly the next cycle, and the shift count increments.
    - When the shift count reaches SHIFTS_PER_LEVEL, the state goes -> TRANS in the cycle after the final shift pulse.
  - TRANS: lasts exactly 1 cycle. transition_Out = 1, level <= level+1 (3 wraps to 0).
    - -> LOAD, so the new-level pattern is loaded one cycle after the register's transition clear.
- Priority, highest first:
  1. Reset.
  2. stop_In: from any state -> IDLE next cycle; level is preserved; any pulse in flight is cancelled.
  3. State transition.
  4. pause_In.
- pause_In and prescaler terminal count in the same cycle: pause wins; no pulse is issued and the prescaler holds.
- start_In outside IDLE is ignored.
- direction_In is sampled only on the wrap cycle; changing it mid-count has no effect until the next pulse.
- At most one of load_OutLow = 0, shiftselection_Out != 00, transition_Out = 1 is active in any cycle.
- Reset asserted mid-RUN or mid-TRANS: immediate return to reset values; level returns to 0.
- A new start after a stop resumes at the preserved level, via LOAD.
- Latency: start_In sampled at edge N -> load_OutLow low during cycle N+1 -> first shift pulse TICK_DIV cycles after the LOAD cycle (with no pause).

Test Plan:
- Reset check (TICK_DIV=4, SHIFTS_PER_LEVEL=3): assert reset mid-RUN -> within the same cycle clear_OutLow=0, load_OutLow=1, shiftselection_Out=00, level_Out=0, data_OutBUS=8'b00000001.
- start pulse, direction_In=0 -> load_OutLow=0 for exactly 1 cycle; shiftselection_Out=01 pulses every 4 cycles, 3 times; then transition_Out=1 for 1 cycle; then load_OutLow=0 with data_OutBUS=8'b00010001, level_Out=1.
- Run 4 full levels -> level_Out sequence 0,1,2,3,0 and data_OutBUS returns to 8'b00000001 after the 4th transition.
- direction_In=1; hold pause_In high for 10 cycles in RUN -> no shift pulses during the pause; the prescaler resumes from its held value and the next 10 pulse is delayed by exactly 10 cycles.
- stop_In during level 2 RUN, then start -> IDLE with clear_OutLow=0; after start, load_OutLow=0 with data_OutBUS=8'b01010101 and the shift count restarts at 0.
- start_In pulsed during RUN; pause_In and prescaler terminal count coincident -> no reload, no pulse; control outputs remain mutually exclusive on every cycle (checked by assertion).
